alu_writeback: RTL and testbench
================================

# alu_writeback

Result writeback stage directly downstream of the 16-bit ALU. It accepts one ALU result per handshake: both result words, the carry/zero/overflow flags, the opcode select and a destination register index. It sequences register-file writes: one write for ordinary ops, two for MUL (low word then high word), none for CMP. It also holds the architectural status flags that the branch logic reads.

## Interface
Parameters:
- DATA_W, 16, ALU result word width
- REG_AW, 3, register-file address width (8 registers)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result present on in_* this cycle
- in_ready  out  1  stage can accept this cycle
- in_sel  in  4  ALU opcode select (0 ADD … 15 NEG; 2 = MUL, 14 = CMP)
- in_dst  in  REG_AW  destination register index
- in_out1  in  DATA_W  ALU high result word (meaningful for MUL only)
- in_out0  in  DATA_W  ALU low/primary result word
- in_c, in_z, in_v  in  1 each  ALU carry, zero and overflow flags
- flush  in  1  synchronous kill of all pending writes
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- stat_c, stat_z, stat_v  out  1 each  architectural status flags
- wb_done  out  1  one-cycle pulse on the final cycle of each accepted op

## Operation
- States: IDLE, WB_LO, WB_HI.
- Accept = in_valid && in_ready.
- in_ready = !flush && (state==IDLE || (state==WB_LO && latched sel!=2)).
- in_ready is low in WB_HI, and low in WB_LO while a MUL is held.
- On accept, latch sel, dst, out1, out0 into holding registers and go to WB_LO. Status flags take in_c/in_z/in_v on that same edge, for every opcode including CMP.
- In WB_LO:
  - rf_we = (sel != 14), rf_waddr = dst, rf_wdata = out0.
  - Next state for MUL (sel==2): WB_HI.
  - Otherwise, with a new accept: WB_LO (new data loaded).
  - Otherwise: IDLE.
- In WB_HI: rf_we = 1, rf_waddr = dst + 1 (wraps modulo 2^REG_AW, so 7→0), rf_wdata = out1. Next state: IDLE.
- wb_done = 1 in WB_LO for non-MUL ops, and in WB_HI for MUL.
- In IDLE: rf_we = 0, wb_done = 0; rf_waddr/rf_wdata hold their last values.
- rf_* and wb_done are decoded from state and holding registers only. There is no combinational path from in_* to rf_*.
- flush (synchronous):
  - Next state is IDLE.
  - In the flush cycle itself, rf_we and wb_done are forced to 0.
  - Holding registers and status flags are unchanged.
  - flush and in_valid in the same cycle: no accept (in_ready is already low).
- Unknown sel values do not exist (4-bit field fully decoded). All non-2, non-14 codes are single-write ops.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - stat_c = stat_z = stat_v = 0
  - wb_done = 0
  - all holding registers = 0
- Reset during WB_HI aborts the second MUL write; no write is issued after reset deasserts.
- Latency, accept at edge N:
  - Single-write op: write visible during cycle N+1.
  - MUL: low write in N+1, high write in N+2.
- Flags are visible from cycle N+1 (the cycle after the accept edge).
- Throughput: one non-MUL op per cycle sustained. MUL occupies 2 cycles; the next accept comes no earlier than the WB_HI→IDLE edge.
- CMP occupies one WB_LO cycle with rf_we = 0 and wb_done = 1.

## Test plan
- Reset, then ADD in_dst=3 in_out0=16'h1234 c=1 z=0 v=0 → next cycle: rf_we=1, waddr=3, wdata=16'h1234, wb_done=1; stat_c=1, stat_v=0.
- MUL in_dst=7 in_out0=16'h5678 in_out1=16'h0009 → cycle+1: write r7=16'h5678 with wb_done=0, in_ready=0; cycle+2: write r0=16'h0009 with wb_done=1.
- Back-to-back SUB (dst 1, 16'h0001) then XOR (dst 2, 16'hFFFF) on consecutive cycles → in_ready stays 1; writes r1 then r2 on consecutive cycles, wb_done high both cycles.
- CMP with in_out0=16'h0002, in_z=0 → rf_we stays 0, wb_done pulses once, stat_z=0; a prior stat_z=1 is overwritten.
- MUL accepted, then flush asserted during WB_LO → no rf_we in the flush cycle or after; state returns to IDLE; in_ready=1 the cycle after.
- rst asserted asynchronously mid-WB_HI → rf_we drops immediately; all outputs take reset values; no write occurs after release.

Source files
------------

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback sequencer with architectural status flags
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_sel,
    input  logic [REG_AW-1:0] in_dst,
    input  logic [DATA_W-1:0] in_out1,
    input  logic [DATA_W-1:0] in_out0,
    input  logic              in_c,
    input  logic              in_z,
    input  logic              in_v,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stat_c,
    output logic              stat_z,
    output logic              stat_v,
    output logic              wb_done
);

    localparam logic [3:0] SEL_MUL = 4'd2;
    localparam logic [3:0] SEL_CMP = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB_LO = 2'd1,
        WB_HI = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          sel_q, sel_d;
    logic [REG_AW-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]   out1_q, out1_d;
    logic [DATA_W-1:0]   out0_q, out0_d;
    logic                stat_c_q, stat_c_d;
    logic                stat_z_q, stat_z_d;
    logic                stat_v_q, stat_v_d;
    logic [REG_AW-1:0]   last_waddr_q, last_waddr_d;
    logic [DATA_W-1:0]   last_wdata_q, last_wdata_d;
    logic                is_mul;
    logic                accept;

    // Decode write port and handshake from state and holding registers; compute next state
    always_comb begin
        is_mul   = (sel_q == SEL_MUL);
        in_ready = !flush && ((state_q == IDLE) || (state_q == WB_LO && !is_mul));
        accept   = in_valid && in_ready;

        rf_we    = 1'b0;
        wb_done  = 1'b0;
        rf_waddr = last_waddr_q;
        rf_wdata = last_wdata_q;
        case (state_q)
            WB_LO: begin
                rf_we    = (sel_q != SEL_CMP);
                rf_waddr = dst_q;
                rf_wdata = out0_q;
                wb_done  = !is_mul;
            end
            WB_HI: begin
                rf_we    = 1'b1;
                rf_waddr = dst_q + REG_AW'(1);
                rf_wdata = out1_q;
                wb_done  = 1'b1;
            end
            default: ;
        endcase
        if (flush) begin
            rf_we   = 1'b0;
            wb_done = 1'b0;
        end

        // Remember what was last presented so the port holds steady while idle
        last_waddr_d = (state_q != IDLE) ? rf_waddr : last_waddr_q;
        last_wdata_d = (state_q != IDLE) ? rf_wdata : last_wdata_q;

        sel_d    = sel_q;
        dst_d    = dst_q;
        out1_d   = out1_q;
        out0_d   = out0_q;
        stat_c_d = stat_c_q;
        stat_z_d = stat_z_q;
        stat_v_d = stat_v_q;
        if (accept) begin
            sel_d    = in_sel;
            dst_d    = in_dst;
            out1_d   = in_out1;
            out0_d   = in_out0;
            stat_c_d = in_c;
            stat_z_d = in_z;
            stat_v_d = in_v;
        end

        case (state_q)
            IDLE:    state_d = accept ? WB_LO : IDLE;
            WB_LO:   state_d = is_mul ? WB_HI : (accept ? WB_LO : IDLE);
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // State, holding registers and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            dst_q        <= '0;
            out1_q       <= '0;
            out0_q       <= '0;
            stat_c_q     <= 1'b0;
            stat_z_q     <= 1'b0;
            stat_v_q     <= 1'b0;
            last_waddr_q <= '0;
            last_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            dst_q        <= dst_d;
            out1_q       <= out1_d;
            out0_q       <= out0_d;
            stat_c_q     <= stat_c_d;
            stat_z_q     <= stat_z_d;
            stat_v_q     <= stat_v_d;
            last_waddr_q <= last_waddr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    assign stat_c = stat_c_q;
    assign stat_z = stat_z_q;
    assign stat_v = stat_v_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - randomized bench for alu_writeback against a write-schedule model
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_sel = '0;
    logic [2:0]  in_dst = '0;
    logic [15:0] in_out1 = '0;
    logic [15:0] in_out0 = '0;
    logic        in_c = 1'b0, in_z = 1'b0, in_v = 1'b0;
    logic        flush = 1'b0;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        stat_c, stat_z, stat_v;
    logic        wb_done;

    alu_writeback #(.DATA_W(16), .REG_AW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_dst(in_dst), .in_out1(in_out1), .in_out0(in_out0),
        .in_c(in_c), .in_z(in_z), .in_v(in_v),
        .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stat_c(stat_c), .stat_z(stat_z), .stat_v(stat_v),
        .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        done;
        logic        hi;
    } wr_t;

    // Model: a queue of register-file writes still owed, one per cycle
    wr_t         pend[$];
    logic [2:0]  m_last_addr;
    logic [15:0] m_last_data;
    logic        m_c, m_z, m_v;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_last_addr = '0;
        m_last_data = '0;
        m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
    endtask

    function automatic logic model_ready(input logic f);
        return !f && (pend.size() == 0 || (pend.size() == 1 && !pend[0].hi));
    endfunction

    // Drive one cycle's inputs, check outputs mid-cycle, then advance the model on the edge
    task automatic step(input logic v, input logic [3:0] s, input logic [2:0] d,
                        input logic [15:0] o1, input logic [15:0] o0,
                        input logic c, input logic z, input logic vv, input logic f);
        logic        e_we, e_done, e_rdy, acc;
        logic [2:0]  e_addr;
        logic [15:0] e_data;
        wr_t         w;
        in_valid = v; in_sel = s; in_dst = d; in_out1 = o1; in_out0 = o0;
        in_c = c; in_z = z; in_v = vv; flush = f;
        @(negedge clk);
        if (pend.size() > 0) begin
            e_we = pend[0].we && !f; e_done = pend[0].done && !f;
            e_addr = pend[0].addr;   e_data = pend[0].data;
        end else begin
            e_we = 1'b0; e_done = 1'b0; e_addr = m_last_addr; e_data = m_last_data;
        end
        e_rdy = model_ready(f);
        check("in_ready", 32'(in_ready), 32'(e_rdy));
        check("rf_we",    32'(rf_we),    32'(e_we));
        check("wb_done",  32'(wb_done),  32'(e_done));
        check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
        check("rf_wdata", 32'(rf_wdata), 32'(e_data));
        check("stat",     {29'd0, stat_c, stat_z, stat_v}, {29'd0, m_c, m_z, m_v});
        @(posedge clk);
        acc = v && e_rdy;
        if (pend.size() > 0) begin
            m_last_addr = pend[0].addr;
            m_last_data = pend[0].data;
            void'(pend.pop_front());
        end
        if (f) begin
            pend.delete();
        end else if (acc) begin
            m_c = c; m_z = z; m_v = vv;
            if (s == 4'd2) begin
                w = '{we: 1'b1, addr: d, data: o0, done: 1'b0, hi: 1'b0};
                pend.push_back(w);
                w = '{we: 1'b1, addr: 3'(d + 3'd1), data: o1, done: 1'b1, hi: 1'b1};
                pend.push_back(w);
            end else begin
                w = '{we: (s != 4'd14), addr: d, data: o0, done: 1'b1, hi: 1'b0};
                pend.push_back(w);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] rs;
        model_reset();
        #1;
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_we",    32'(rf_we), 32'd0);
        check("reset_addr",  32'(rf_waddr), 32'd0);
        check("reset_data",  32'(rf_wdata), 32'd0);
        check("reset_flags", {29'd0, stat_c, stat_z, stat_v}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD to r3
        step(1'b1, 4'd0, 3'd3, 16'h0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        check("add_we_fixed",   32'(rf_we), 32'd1);
        check("add_addr_fixed", 32'(rf_waddr), 32'd3);
        check("add_data_fixed", 32'(rf_wdata), 32'h1234);
        check("add_c_fixed",    32'(stat_c), 32'd1);
        idle(1);
        // MUL to r7 wraps high half to r0
        step(1'b1, 4'd2, 3'd7, 16'h0009, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mul_lo_addr", 32'(rf_waddr), 32'd7);
        check("mul_lo_busy", 32'(in_ready), 32'd0);
        step(1'b1, 4'd0, 3'd1, 16'h0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mul_hi_addr", 32'(rf_waddr), 32'd0);
        check("mul_hi_data", 32'(rf_wdata), 32'h0009);
        idle(1);
        // Back-to-back SUB, XOR
        step(1'b1, 4'd1, 3'd1, 16'h0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd5, 3'd2, 16'h0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        // CMP overwrites a set Z flag
        step(1'b1, 4'd14, 3'd4, 16'h0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cmp_z_fixed", 32'(stat_z), 32'd0);
        idle(1);
        // MUL then flush during WB_LO
        step(1'b1, 4'd2, 3'd5, 16'h1111, 16'h2222, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'd3, 3'd6, 16'h0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Async reset in the middle of WB_HI
        step(1'b1, 4'd2, 3'd6, 16'hBEEF, 16'hCAFE, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("pre_rst_we", 32'(rf_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_we",    32'(rf_we), 32'd0);
        check("rst_done",  32'(wb_done), 32'd0);
        check("rst_addr",  32'(rf_waddr), 32'd0);
        check("rst_data",  32'(rf_wdata), 32'd0);
        check("rst_flags", {29'd0, stat_c, stat_z, stat_v}, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rs = 4'd2;
                1: rs = 4'd14;
                default: rs = 4'($urandom_range(0, 15));
            endcase
            step(($urandom_range(0, 9) < 7), rs, 3'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
